// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the MMIO UART write path and the uart transmitter.
// Bytes are pushed at bus speed and drained one at a time through the uart
// sendData/sendReq/ready handshake. Level, full, empty and a sticky overflow flag
// are exposed for MMIO status reads.
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [DEPTH_BITS:0]   level,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    input  logic                  tx_ready
);

    // Transmit handshake states: wait for a byte, wait for the uart to go busy,
    // then wait for it to return to idle before the next pop.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_t;

    localparam logic [DEPTH_BITS:0]   COUNT_ZERO = {(DEPTH_BITS+1){1'b0}};
    localparam logic [DEPTH_BITS:0]   COUNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS:0]   COUNT_FULL = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO   = {DEPTH_BITS{1'b0}};
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS:0]   count_r;
    tx_state_t             state_r;
    logic [7:0]            tx_data_r;
    logic                  tx_send_r;
    logic                  overflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;
    logic                  busy_s;

    // Status decode and push/pop qualification, all from pre-edge register state.
    always_comb begin
        full_s  = 1'b0;
        empty_s = 1'b0;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        pop_s   = 1'b0;
        busy_s  = 1'b0;
        if (count_r == COUNT_FULL) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r == COUNT_ZERO) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        // A push into a full FIFO is dropped even when a pop happens on the same edge.
        push_s = wr_en && !full_s;
        drop_s = wr_en && full_s;
        // Pops only see entries written on earlier edges (pre-edge empty flag).
        if ((state_r == ST_IDLE) && !empty_s && tx_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        busy_s = (state_r != ST_IDLE) || !empty_s;
    end

    // Storage array write; contents are not reset, the pointers flush them logically.
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Write pointer, read pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a dropped push wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end

    // Transmit handshake FSM with registered sendData/sendReq.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            tx_data_r <= 8'h00;
            tx_send_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r <= mem_r[rd_ptr_r];
                        tx_send_r <= 1'b1;
                        state_r   <= ST_WAIT_BUSY;
                    end else begin
                        tx_send_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WAIT_BUSY: begin
                    tx_send_r <= 1'b0;
                    if (!tx_ready) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    tx_send_r <= 1'b0;
                    if (tx_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_send_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign overflow = overflow_r;
    assign level    = count_r;
    assign busy     = busy_s;
    assign tx_data  = tx_data_r;
    assign tx_send  = tx_send_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo. A queue-based model tracks
// the FIFO contents and overflow flag; a small uart model drops ready for a number
// of cycles after each sendReq.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [4:0] level;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_ready;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .level    (level),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       ovf_m = 1'b0;
    logic [7:0] last_data_m = 8'h00;
    bit         prev_send = 1'b0;
    int         sent_cnt = 0;
    bit         hold_mode = 1'b1;
    bit         hold_val = 1'b0;
    int         uart_cnt = 0;
    int         gap_min = 1;
    int         gap_max = 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, update the model after posedge, check.
    task automatic step(input bit we, input logic [7:0] wd, input bit clr, input bit rstn);
        int pre_size;
        bit pre_ready;
        bit accept;
        bit drop;
        @(negedge clk);
        if (hold_mode) begin
            tx_ready = hold_val;
        end else begin
            tx_ready = (uart_cnt == 0);
            if (uart_cnt > 0) uart_cnt--;
        end
        wr_en   = we;
        wr_data = wd;
        ovf_clr = clr;
        resetn  = rstn;
        pre_size  = q.size();
        pre_ready = tx_ready;
        accept = we && rstn && (pre_size < DEPTH);
        drop   = we && rstn && (pre_size >= DEPTH);
        @(posedge clk);
        #1;
        if (!rstn) begin
            q.delete();
            ovf_m = 1'b0;
            last_data_m = 8'h00;
            check_eq("rst_send", tx_send, 1'b0);
            check_eq("rst_data", tx_data, 8'h00);
            check_eq("rst_busy", busy, 1'b0);
        end else begin
            if (tx_send) begin
                check_eq("send_while_not_ready", pre_ready, 1'b1);
                check_eq("send_from_empty", pre_size != 0, 1'b1);
                check_eq("send_back_to_back", prev_send, 1'b0);
                if (q.size() > 0) last_data_m = q.pop_front();
                sent_cnt++;
                uart_cnt = $urandom_range(gap_max, gap_min);
            end
            check_eq("tx_data", tx_data, last_data_m);
            if (accept) q.push_back(wd);
            if (drop) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
        end
        prev_send = tx_send;
        check_eq("level", level, q.size());
        check_eq("full", full, q.size() == DEPTH);
        check_eq("empty", empty, q.size() == 0);
        check_eq("overflow", overflow, ovf_m);
        if (q.size() != 0) check_eq("busy", busy, 1'b1);
    endtask

    // Let the uart model run with no pushes until the model queue drains.
    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q.size() != 0 || uart_cnt != 0) && n < max_cycles) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_timeout", q.size(), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("drain_busy", busy, 1'b0);
    endtask

    task automatic do_reset(input bit rdy_hold, input bit rdy_val);
        hold_mode = rdy_hold;
        hold_val  = rdy_val;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        sent_cnt = 0;
    endtask

    initial begin
        resetn   = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        ovf_clr  = 1'b0;
        tx_ready = 1'b0;

        // Reset state and single-byte latency.
        do_reset(1'b1, 1'b1);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_level", level, 0);
        step(1'b1, 8'h41, 1'b0, 1'b1);
        check_eq("t1_no_send_yet", tx_send, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t1_send", tx_send, 1'b1);
        check_eq("t1_data", tx_data, 8'h41);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t1_send_low", tx_send, 1'b0);
        check_eq("t1_level", level, 0);

        // Fill to full with ready held low, overflow, then drain in order.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        check_eq("t2_full", full, 1'b1);
        check_eq("t2_level", level, 16);
        check_eq("t2_ovf", overflow, 1'b1);
        hold_mode = 1'b0;
        uart_cnt = 0;
        gap_min = 3;
        gap_max = 3;
        drain(600);
        check_eq("t2_sent", sent_cnt, 16);

        // Slow uart, 20 bytes pushed over time across the pointer wrap.
        do_reset(1'b0, 1'b0);
        uart_cnt = 0;
        gap_min = 10;
        gap_max = 10;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b1);
            for (int j = 0; j < 3; j++) step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        drain(600);
        check_eq("t3_sent", sent_cnt, 20);
        check_eq("t3_ovf", overflow, 1'b0);

        // Push and pop on the same edge at 15 and 16 entries; overflow set/clear priority.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        hold_val = 1'b1;
        step(1'b1, 8'h50, 1'b0, 1'b1);
        check_eq("t4_pop15", tx_send, 1'b1);
        check_eq("t4_level15", level, 15);
        check_eq("t4_no_ovf", overflow, 1'b0);
        hold_val = 1'b0;
        step(1'b1, 8'h51, 1'b0, 1'b1);
        check_eq("t4_level16", level, 16);
        hold_val = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h52, 1'b0, 1'b1);
        check_eq("t4_pop16", tx_send, 1'b1);
        check_eq("t4_drop_level", level, 15);
        check_eq("t4_drop_ovf", overflow, 1'b1);
        hold_val = 1'b0;
        step(1'b1, 8'h53, 1'b1, 1'b1);
        check_eq("t5_refill", level, 16);
        check_eq("t5_clear_then", overflow, 1'b0);
        step(1'b1, 8'h54, 1'b1, 1'b1);
        check_eq("t5_set_wins", overflow, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("t5_clear", overflow, 1'b0);

        // Reset with entries queued and the FSM waiting for the uart frame to end.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
        hold_val = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t6_level5", level, 5);
        check_eq("t6_sent1", sent_cnt, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t6_empty", empty, 1'b1);
        check_eq("t6_level0", level, 0);
        hold_val = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t6_no_more_sends", sent_cnt, 1);
        check_eq("t6_idle", busy, 1'b0);

        // Randomized traffic against the queue model.
        do_reset(1'b0, 1'b0);
        uart_cnt = 0;
        gap_min = 1;
        gap_max = 6;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 5, 1'b1);
        end
        drain(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
